// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI MISO-path serializer.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SPI_DATA_W = 8;

endpackage

// File: rtl/spi_tx_hold.sv
// One-entry holding buffer between the RAM read port and the shifter.
module spi_tx_hold
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    input  logic              drain,
    output logic              tx_ready,
    output logic              buf_full,
    output logic [DATA_W-1:0] buf_data
);

    logic              full_q, full_d;
    logic              ready_q;
    logic [DATA_W-1:0] data_q, data_d;

    // Drain only happens when full and accept only when empty, so they never collide.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (drain) begin
            full_d = 1'b0;
        end else if (tx_valid && ready_q) begin
            full_d = 1'b1;
            data_d = tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q  <= 1'b0;
            ready_q <= 1'b1;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= !full_d;
            data_q  <= data_d;
        end
    end

    assign tx_ready = ready_q;
    assign buf_full = full_q;
    assign buf_data = data_q;

endmodule

// File: rtl/spi_serializer.sv
// Parallel-to-serial converter for the SPI slave MISO path; one bit per ser_en strobe,
// with back-to-back reload from the holding buffer so a kept-full buffer streams gap-free.
module spi_serializer
    import spi_pkg::*;
#(
    parameter int DATA_W    = SPI_DATA_W,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              ser_en,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    ser_state_t        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, shifted;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              sout_q, sout_d;
    logic              drain;
    logic              buf_full;
    logic [DATA_W-1:0] buf_data;

    spi_tx_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .drain    (drain),
        .tx_ready (tx_ready),
        .buf_full (buf_full),
        .buf_data (buf_data)
    );

    always_comb begin
        if (MSB_FIRST != 0) shifted = {shift_q[DATA_W-2:0], 1'b0};
        else                shifted = {1'b0, shift_q[DATA_W-1:1]};
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        drain   = 1'b0;
        case (state_q)
            IDLE: begin
                if (buf_full) begin
                    shift_d = buf_data;
                    cnt_d   = '0;
                    drain   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_en) begin
                    if (cnt_q == LAST_BIT) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                        if (buf_full) begin
                            shift_d = buf_data;
                            drain   = 1'b1;
                        end else begin
                            shift_d = shifted;
                            state_d = IDLE;
                        end
                    end else begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from next-state values so they line up with the state.
        busy_d = (state_d == SHIFT);
        if (state_d == SHIFT) sout_d = (MSB_FIRST != 0) ? shift_d[DATA_W-1] : shift_d[0];
        else                  sout_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            sout_q  <= sout_d;
        end
    end

    assign serial_out = sout_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_spi_serializer.sv
// Bench for spi_serializer: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a word-queue model, plus literal expectations per scenario.
module tb_spi_serializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         ser_en = 1'b0;
    logic         rdy_m, so_m, busy_m, done_m;
    logic         rdy_l, so_l, busy_l, done_l;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    spi_serializer #(.DATA_W(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy_m),
        .ser_en(ser_en), .serial_out(so_m), .busy(busy_m), .done(done_m)
    );

    spi_serializer #(.DATA_W(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy_l),
        .ser_en(ser_en), .serial_out(so_l), .busy(busy_l), .done(done_l)
    );

    // Behavioural model: one buffered word, one word in flight, index of the bit on the line.
    bit           m_full = 0, m_active = 0, m_done = 0;
    logic [W-1:0] m_buf = '0, m_word = '0;
    int           m_idx = 0;

    always @(posedge clk or posedge rst) begin : model
        bit acc, nd;
        if (rst) begin
            m_full = 0; m_active = 0; m_done = 0; m_idx = 0;
        end else begin
            acc = tx_valid && !m_full;
            nd  = 0;
            if (!m_active) begin
                if (m_full) begin
                    m_active = 1; m_word = m_buf; m_idx = 0; m_full = 0;
                end
            end else if (ser_en) begin
                if (m_idx == W - 1) begin
                    nd = 1;
                    if (m_full) begin
                        m_word = m_buf; m_idx = 0; m_full = 0;
                    end else begin
                        m_active = 0;
                    end
                end else begin
                    m_idx++;
                end
            end
            if (acc) begin
                m_full = 1; m_buf = tx_data;
            end
            m_done = nd;
        end
    end

    // Observation of the line: bits consumed, done pulses and their cycle numbers.
    logic [31:0] cap_m = '0, cap_l = '0;
    int cons = 0, dones_m = 0, dones_l = 0, cyc = 0, d_last = 0, d_prev = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (busy_m && ser_en) begin
                cap_m <= {cap_m[30:0], so_m};
                cap_l <= {cap_l[30:0], so_l};
                cons  <= cons + 1;
            end
            if (done_m) begin
                dones_m <= dones_m + 1;
                d_prev  <= d_last;
                d_last  <= cyc;
            end
            if (done_l) dones_l <= dones_l + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        logic e_m, e_l;
        e_m = m_active ? m_word[W-1-m_idx] : 1'b0;
        e_l = m_active ? m_word[m_idx] : 1'b0;
        check("m.tx_ready", 32'(rdy_m), 32'(!m_full));
        check("m.busy", 32'(busy_m), 32'(m_active));
        check("m.done", 32'(done_m), 32'(m_done));
        check("m.serial_out", 32'(so_m), 32'(e_m));
        check("l.tx_ready", 32'(rdy_l), 32'(!m_full));
        check("l.busy", 32'(busy_l), 32'(m_active));
        check("l.done", 32'(done_l), 32'(m_done));
        check("l.serial_out", 32'(so_l), 32'(e_l));
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".tx_ready"}, 32'(rdy_m), 32'd1);
        check({tag, ".serial_out"}, 32'(so_m), 32'd0);
        check({tag, ".busy"}, 32'(busy_m), 32'd0);
        check({tag, ".done"}, 32'(done_m), 32'd0);
        check({tag, ".l_tx_ready"}, 32'(rdy_l), 32'd1);
        check({tag, ".l_busy"}, 32'(busy_l), 32'd0);
    endtask

    // Present a word and return at the falling edge right after the accepting edge.
    task automatic send(input logic [W-1:0] d);
        bit acc;
        acc = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        for (int i = 0; i < 64; i++) begin
            acc = rdy_m;
            tick();
            if (acc) break;
        end
        tx_valid = 1'b0;
        check("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_done_out(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done_m) begin
                seen = 1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        int base_c, base_d;
        bit seen3;

        // Reset from power-up
        tick(); tick();
        check_reset_outputs("por");
        rst = 1'b0;
        tick();

        // Single word 0xA5, ser_en held high
        ser_en = 1'b1;
        base_c = cons; base_d = dones_m;
        send(8'hA5);
        check("a5_busy_after_accept", 32'(busy_m), 32'd0);
        check("a5_ready_after_accept", 32'(rdy_m), 32'd0);
        tick();
        check("a5_busy_first_bit", 32'(busy_m), 32'd1);
        check("a5_first_bit_m", 32'(so_m), 32'd1);
        check("a5_first_bit_l", 32'(so_l), 32'd1);
        wait_done_out("a5_done_seen");
        check("a5_busy_at_done", 32'(busy_m), 32'd0);
        tick();
        check("a5_bits_m", cap_m & 32'hFF, 32'hA5);
        check("a5_bits_l", cap_l & 32'hFF, 32'hA5);
        check("a5_consumed", 32'(cons - base_c), 32'd8);
        check("a5_done_count", 32'(dones_m - base_d), 32'd1);
        check("a5_done_count_l", 32'(dones_l - base_d), 32'd1);

        // Same word with gaps in ser_en
        ser_en = 1'b0;
        base_c = cons; base_d = dones_m;
        send(8'hA5);
        for (int k = 0; k < 100; k++) begin
            ser_en = (k % 3 == 0);
            tick();
            if (done_m) break;
        end
        ser_en = 1'b0;
        tick(); tick();
        check("gap_bits_m", cap_m & 32'hFF, 32'hA5);
        check("gap_consumed", 32'(cons - base_c), 32'd8);
        check("gap_done_count", 32'(dones_m - base_d), 32'd1);

        // Back-to-back 0x3C then 0xC3
        ser_en = 1'b1;
        base_c = cons; base_d = dones_m;
        send(8'h3C);
        send(8'hC3);
        wait_done_out("b2b_done1");
        wait_done_out("b2b_done2");
        tick();
        check("b2b_bits_m", cap_m & 32'hFFFF, 32'h3CC3);
        check("b2b_bits_l", cap_l & 32'hFFFF, 32'h3CC3);
        check("b2b_consumed", 32'(cons - base_c), 32'd16);
        check("b2b_done_count", 32'(dones_m - base_d), 32'd2);
        check("b2b_done_spacing", 32'(d_last - d_prev), 32'd8);

        // 0x01: LSB-first puts the 1 on the line first
        base_d = dones_m;
        send(8'h01);
        tick();
        check("x01_first_bit_l", 32'(so_l), 32'd1);
        check("x01_first_bit_m", 32'(so_m), 32'd0);
        wait_done_out("x01_done");
        tick();
        check("x01_bits_m", cap_m & 32'hFF, 32'h01);
        check("x01_bits_l", cap_l & 32'hFF, 32'h80);

        // Reset in the middle of 0xFF with 0x55 buffered
        base_c = cons;
        send(8'hFF);
        send(8'h55);
        seen3 = 0;
        for (int i = 0; i < 40; i++) begin
            if (cons - base_c >= 3) begin
                seen3 = 1;
                break;
            end
            tick();
        end
        check("rst_mid_3bits", 32'(seen3), 32'd1);
        check("rst_mid_buffer_full", 32'(rdy_m), 32'd0);
        base_d = dones_m;
        #2 rst = 1'b1;
        #1 check_reset_outputs("async");
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_no_done", 32'(dones_m - base_d), 32'd0);
        check("rst_ready_after", 32'(rdy_m), 32'd1);
        base_c = cons;
        send(8'h0F);
        wait_done_out("x0f_done");
        tick(); tick();
        check("x0f_bits_m", cap_m & 32'hFF, 32'h0F);
        check("x0f_bits_l", cap_l & 32'hFF, 32'hF0);
        check("x0f_consumed", 32'(cons - base_c), 32'd8);
        check("x0f_done_count", 32'(dones_m - base_d), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            tx_valid = ($urandom_range(0, 2) != 0);
            tx_data  = W'($urandom);
            ser_en   = ($urandom_range(0, 3) != 0);
            tick();
        end
        tx_valid = 1'b0;
        ser_en   = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        check("rand_idle_at_end", 32'(busy_m), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
